sdr_io_bus: RTL and testbench
=============================

# sdr_io_bus

Parametrised bidirectional pad-bus controller between the SDR modulator/demodulator core and the off-chip data bus. Time-multiplexes one WIDTH-bit tri-state bus between transmit (core drives pins) and receive (pins feed demod). Adds three things on top of a plain direction mux: a registered transmit handshake, a synchronised receive path with a valid flag, and a guaranteed hi-Z turnaround window on every direction change so the chip and the FPGA never drive the bus at the same time.

## Interface
- WIDTH, 8, bus and data width (≥1)
- TURN_CYCLES, 2, hi-Z cycles inserted on each direction change (≥1)
- SYNC_STAGES, 2, flip-flop stages on the receive path (≥2)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- mode_sel  input  1  requested direction: 0 = TX (modulate), 1 = RX (demodulate)
- tx_data  input  WIDTH  word from the modulator
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block accepts tx_data this cycle
- rx_data  output  WIDTH  synchronised bus word to the demodulator; 0 when rx_valid = 0
- rx_valid  output  1  rx_data is valid
- dir_tx  output  1  1 while in TX state
- turn  output  1  1 while in a turnaround state
- IO  inout  WIDTH  off-chip bus; driven with tx_reg when oe = 1, otherwise 'z

## Operation
- State machine states:
  - RX: oe = 0.
  - TURN: oe = 0; turn_cnt counts down.
  - TX: oe = 1.
- Reset state is RX. Outputs during reset:
  - tx_ready = 0, rx_valid = 0, rx_data = 0, dir_tx = 0, turn = 0.
  - tx_reg = 0, turn_cnt = 0, fill_cnt = 0, sync chain = 0.
- RX → TURN: when mode_sel = 0 is sampled in RX. turn_cnt loads TURN_CYCLES−1.
- TX → TURN: when mode_sel = 1 is sampled in TX. turn_cnt loads TURN_CYCLES−1.
- Exit from TURN: when turn_cnt = 0, mode_sel sampled on that same cycle selects the next state (0 → TX, 1 → RX). The exit is therefore allowed to return to the original direction.
- A mode_sel toggle during TURN does not extend or restart the turnaround.
- TX path:
  - tx_ready = 1 only in TX.
  - When tx_valid & tx_ready, tx_reg ← tx_data.
  - IO drives tx_reg. tx_reg holds its value between accepts.
  - Leaving TX clears tx_reg to 0, so every TX entry drives 0 until the first accept.
- RX path:
  - IO passes through the SYNC_STAGES-deep chain every cycle, in all states.
  - fill_cnt clears on any cycle not in RX.
  - fill_cnt increments in RX and saturates at SYNC_STAGES.
  - rx_valid = (state == RX) && fill_cnt == SYNC_STAGES.
  - rx_data = last sync stage when rx_valid = 1, otherwise 0.
- tx_valid outside TX is ignored; the word is neither accepted nor queued.
- A reset asserted mid-TX releases the bus to hi-Z combinationally (oe = 0) and clears all state.

## Timing
- TX latency: accept at edge N → IO shows the word after edge N.
- Turnaround: oe is low for exactly TURN_CYCLES consecutive cycles between the last TX-driven cycle and the first RX cycle, and likewise in the RX-to-TX direction.
- Direction-change request to new state: 1 + TURN_CYCLES cycles (one cycle to sample mode_sel, then TURN_CYCLES cycles in TURN).
- RX latency: bus value → rx_data in SYNC_STAGES cycles.
- rx_valid rises SYNC_STAGES cycles after RX entry, including the entry after reset release.
- dir_tx, turn and tx_ready are registered-state decodes; they glitch-free track state.

## Configuration
- IO_BUS_LOOPBACK_EN defined:
  - Adds input port lpbk (1 bit).
  - In TX with lpbk = 1, fill_cnt runs as it does in RX, and rx_valid/rx_data report the synchronised driven bus (readback of tx_reg, SYNC_STAGES cycles late).
  - lpbk is ignored in RX and TURN.
- Macro undefined:
  - Port lpbk is absent.
  - rx_valid = 0 and rx_data = 0 in every state except RX.

## Test plan
- Reset release, mode_sel = 1, IO driven 8'hA5 externally → IO stays hi-Z, tx_ready = 0; rx_valid = 1 with rx_data = 8'hA5 exactly 2 cycles after reset release.
- mode_sel 1→0, TURN_CYCLES = 2 → turn = 1 and oe = 0 for exactly 2 cycles, then dir_tx = 1 and IO = 8'h00; rx_valid = 0 from the first TURN cycle onward.
- In TX, tx_valid with 8'h3C then 8'hC3 on consecutive cycles → IO = 8'h3C then 8'hC3, each one cycle after its accept; IO holds 8'hC3 while tx_valid = 0.
- In TX, pulse mode_sel to 1 for one cycle during TURN, back to 0 at turn_cnt = 0 → after 2 hi-Z cycles, returns to TX driving 8'h00; no RX cycle occurs.
- Assert rst mid-TX while IO = 8'hFF → IO goes hi-Z immediately, outputs at reset values, RX state after release.
- With IO_BUS_LOOPBACK_EN, TX, lpbk = 1, accept 8'h5A → rx_valid = 1 and rx_data = 8'h5A, 2 cycles after IO shows 8'h5A.

Source files
------------

// File: rtl/sdr_io_bus_if.sv
// rtl/sdr_io_bus_if.sv - core-side handshake bundle for sdr_io_bus
// IO_BUS_LOOPBACK_EN adds the lpbk request line.
interface sdr_io_bus_if #(
  parameter int WIDTH = 8
);
  logic             mode_sel;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             dir_tx;
  logic             turn;
`ifdef IO_BUS_LOOPBACK_EN
  logic             lpbk;
`endif

  modport master (
`ifdef IO_BUS_LOOPBACK_EN
    output lpbk,
`endif
    output mode_sel, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, dir_tx, turn
  );

  modport slave (
`ifdef IO_BUS_LOOPBACK_EN
    input  lpbk,
`endif
    input  mode_sel, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, dir_tx, turn
  );
endinterface

// File: rtl/sdr_io_bus.sv
// rtl/sdr_io_bus.sv - tri-state pad bus controller with hi-Z turnaround and synchronised receive path
// IO_BUS_LOOPBACK_EN enables TX readback through the receive synchroniser.
module sdr_io_bus #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sdr_io_bus_if.slave      bus,
  inout  wire  [WIDTH-1:0] IO
);
  localparam int CNT_W  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_TURN = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] turn_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             oe;
  logic             rx_window;

  // rst gates oe directly so the pads release even before the state flops settle.
  assign oe = (state == ST_TX) && !rst;
  assign IO = oe ? tx_reg : {WIDTH{1'bz}};

`ifdef IO_BUS_LOOPBACK_EN
  assign rx_window = (state == ST_RX) || ((state == ST_TX) && bus.lpbk);
`else
  assign rx_window = (state == ST_RX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RX;
      turn_cnt <= '0;
    end else begin
      case (state)
        ST_RX: begin
          if (!bus.mode_sel) begin
            state    <= ST_TURN;
            turn_cnt <= CNT_W'(TURN_CYCLES - 1);
          end
        end
        ST_TX: begin
          if (bus.mode_sel) begin
            state    <= ST_TURN;
            turn_cnt <= CNT_W'(TURN_CYCLES - 1);
          end
        end
        ST_TURN: begin
          // mode_sel only matters on the final turnaround cycle.
          if (turn_cnt == '0) begin
            state <= bus.mode_sel ? ST_RX : ST_TX;
          end else begin
            turn_cnt <= turn_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg <= '0;
    end else if (state == ST_TX) begin
      if (bus.mode_sel) begin
        tx_reg <= '0;
      end else if (bus.tx_valid) begin
        tx_reg <= bus.tx_data;
      end
    end else begin
      tx_reg <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (!rx_window) begin
      fill_cnt <= '0;
    end else if (fill_cnt != FILL_W'(SYNC_STAGES)) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= IO;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus.tx_ready = (state == ST_TX);
  assign bus.dir_tx   = (state == ST_TX);
  assign bus.turn     = (state == ST_TURN);
  assign bus.rx_valid = rx_window && (fill_cnt == FILL_W'(SYNC_STAGES));
  assign bus.rx_data  = bus.rx_valid ? sync_q[SYNC_STAGES-1] : '0;
endmodule

// File: tb/tb_sdr_io_bus.sv
// tb/tb_sdr_io_bus.sv - randomized bench for sdr_io_bus against a timestamp-based reference model
// Build with IO_BUS_LOOPBACK_EN to cover readback.
module tb_sdr_io_bus;
  localparam int W = 8;
  localparam int T = 2;
  localparam int S = 2;
`ifdef IO_BUS_LOOPBACK_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif
  localparam int P_RX = 0, P_TURN = 1, P_TX = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ext_en;
  logic [W-1:0] ext_val;
  wire  [W-1:0] IO;

  sdr_io_bus_if #(.WIDTH(W)) bus ();

  sdr_io_bus #(.WIDTH(W), .TURN_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .IO (IO)
  );

  assign IO = ext_en ? ext_val : {W{1'bz}};

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: bus direction, turnaround end timestamp, window run length, IO history.
  int           phase;
  int           turn_end;
  int           cyc;
  int           run;
  logic [W-1:0] tx_word;
  logic [W-1:0] io_cur;
  logic [W-1:0] hist [$];
  bit           cur_m, cur_v, cur_lp;
  logic [W-1:0] cur_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase   = P_RX;
    cyc     = 0;
    run     = 0;
    tx_word = '0;
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back('0);
  endtask

  function automatic bit in_window();
    return (phase == P_RX) || (phase == P_TX && LP_EN && cur_lp);
  endfunction

  task automatic check_model();
    bit           ev;
    logic [W-1:0] ed;
    ev = in_window() && (run >= S);
    ed = ev ? hist[hist.size()-S] : '0;
    chk("tx_ready", 32'(bus.tx_ready), 32'(phase == P_TX));
    chk("dir_tx",   32'(bus.dir_tx),   32'(phase == P_TX));
    chk("turn",     32'(bus.turn),     32'(phase == P_TURN));
    chk("oe",       32'(dut.oe),       32'(phase == P_TX));
    if (phase == P_TX) chk("io_drive", 32'(IO), 32'(tx_word));
    chk("rx_valid", 32'(bus.rx_valid), 32'(ev));
    chk("rx_data",  32'(bus.rx_data),  32'(ed));
  endtask

  // Drive one cycle's inputs (at the falling edge) and compare the model.
  task automatic cyc_in(input bit m, input bit v, input logic [W-1:0] d,
                        input logic [W-1:0] e, input bit lp);
    cur_m = m; cur_v = v; cur_d = d; cur_lp = lp;
    bus.mode_sel = m;
    bus.tx_valid = v;
    bus.tx_data  = d;
`ifdef IO_BUS_LOOPBACK_EN
    bus.lpbk     = lp;
`endif
    ext_en  = (phase != P_TX);
    ext_val = e;
    io_cur  = (phase == P_TX) ? tx_word : e;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit win;
    @(posedge clk);
    #1;
    win = in_window();
    run = win ? ((run < S) ? run + 1 : S) : 0;
    hist.push_back(io_cur);
    if (hist.size() > 8) void'(hist.pop_front());
    if (phase == P_TX) tx_word = cur_m ? '0 : (cur_v ? cur_d : tx_word);
    else               tx_word = '0;
    if (phase == P_RX && !cur_m) begin
      phase = P_TURN; turn_end = cyc + T;
    end else if (phase == P_TX && cur_m) begin
      phase = P_TURN; turn_end = cyc + T;
    end else if (phase == P_TURN && cyc == turn_end) begin
      phase = cur_m ? P_RX : P_TX;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input bit m, input bit v, input logic [W-1:0] d,
                      input logic [W-1:0] e, input bit lp);
    cyc_in(m, v, d, e, lp);
    tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data",  32'(bus.rx_data),  32'd0);
    chk("rst_dir_tx",   32'(bus.dir_tx),   32'd0);
    chk("rst_turn",     32'(bus.turn),     32'd0);
    chk("rst_oe",       32'(dut.oe),       32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    ext_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit           m, lp;
    rst          = 1'b1;
    ext_en       = 1'b1;
    ext_val      = 8'hA5;
    bus.mode_sel = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
`ifdef IO_BUS_LOOPBACK_EN
    bus.lpbk     = 1'b0;
`endif
    cur_lp = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    model_reset();

    // Reset release in RX with external A5 on the bus.
    cyc_in(1, 0, 8'h00, 8'hA5, 0);
    chk("lit_rx_valid_c0", 32'(bus.rx_valid), 32'd0);
    tick();
    step(1, 0, 8'h00, 8'hA5, 0);
    cyc_in(0, 0, 8'h00, 8'hA5, 0);
    chk("lit_rx_valid_c2", 32'(bus.rx_valid), 32'd1);
    chk("lit_rx_data_c2",  32'(bus.rx_data),  32'hA5);
    chk("lit_hiz_c2",      32'(dut.oe),       32'd0);
    tick();

    // RX -> TX turnaround.
    cyc_in(0, 0, 8'h00, 8'h11, 0);
    chk("lit_turn1", 32'(bus.turn), 32'd1);
    chk("lit_turn1_rxv", 32'(bus.rx_valid), 32'd0);
    tick();
    cyc_in(0, 0, 8'h00, 8'h22, 0);
    chk("lit_turn2", 32'(bus.turn), 32'd1);
    chk("lit_turn2_oe", 32'(dut.oe), 32'd0);
    tick();
    cyc_in(0, 1, 8'h3C, 8'h00, 0);
    chk("lit_tx_entry_dir", 32'(bus.dir_tx), 32'd1);
    chk("lit_tx_entry_io",  32'(IO), 32'h00);
    tick();
    cyc_in(0, 1, 8'hC3, 8'h00, 0);
    chk("lit_io_3c", 32'(IO), 32'h3C);
    tick();
    cyc_in(0, 0, 8'h00, 8'h00, 0);
    chk("lit_io_c3", 32'(IO), 32'hC3);
    tick();

    // TX -> TURN with a mode pulse, back to TX without visiting RX.
    cyc_in(1, 0, 8'h00, 8'h00, 0);
    chk("lit_io_c3_hold", 32'(IO), 32'hC3);
    tick();
    cyc_in(1, 0, 8'h00, 8'h77, 0);
    chk("lit_pulse_turn1", 32'(bus.turn), 32'd1);
    tick();
    cyc_in(0, 0, 8'h00, 8'h77, 0);
    chk("lit_pulse_turn2", 32'(bus.turn), 32'd1);
    tick();
    cyc_in(0, 1, 8'hFF, 8'h00, 0);
    chk("lit_back_tx_dir", 32'(bus.dir_tx), 32'd1);
    chk("lit_back_tx_io",  32'(IO), 32'h00);
    tick();
    cyc_in(0, 0, 8'h00, 8'h00, 0);
    chk("lit_io_ff", 32'(IO), 32'hFF);

    // Reset mid-TX.
    do_reset();
    cyc_in(1, 0, 8'h00, 8'h5C, 0);
    chk("lit_post_rst_dir", 32'(bus.dir_tx), 32'd0);
    chk("lit_post_rst_turn", 32'(bus.turn), 32'd0);
    tick();

`ifdef IO_BUS_LOOPBACK_EN
    step(0, 0, 8'h00, 8'h00, 1);
    step(0, 0, 8'h00, 8'h00, 1);
    step(0, 0, 8'h00, 8'h00, 1);
    step(0, 1, 8'h5A, 8'h00, 1);
    cyc_in(0, 0, 8'h00, 8'h00, 1);
    chk("lit_lpbk_io", 32'(IO), 32'h5A);
    tick();
    step(0, 0, 8'h00, 8'h00, 1);
    cyc_in(0, 0, 8'h00, 8'h00, 1);
    chk("lit_lpbk_valid", 32'(bus.rx_valid), 32'd1);
    chk("lit_lpbk_data",  32'(bus.rx_data),  32'h5A);
    tick();
`endif

    // Randomized traffic.
    m  = 1'b1;
    lp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) m = ~m;
      if ($urandom_range(0, 15) == 0) lp = ~lp;
      step(m, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), lp);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
